// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of requester and memory-side signals for dmem_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester access fields
//   ack0/ack1, err, rdata, busy                    : completion and status back to requesters
//   mem_addr, mem_wdata, mem_we, mem_re            : arbiter to single-port memory
//   mem_rdata                                      : memory read data (combinational from mem_addr)
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word-addressed data memory between port 0 (CPU)
// and port 1 (DMA/loader). Accesses are serialised through IDLE -> ACCESS -> RESP,
// with WAIT_CYC extra ACCESS cycles. Addresses >= DEPTH complete with err and never
// touch the memory.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : dmem_arbiter_if.slave (requester handshakes, status, memory interface)
// Configuration macro DMEM_ARB_RR_EN: defined = round-robin tie-break (port not granted
// last wins); undefined = fixed priority, port 0 always wins a tie.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned WAIT_CYC = 0
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [3:0]        WaitLast  = 4'(WAIT_CYC);
  localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              any_req;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_cycle;
  logic              in_access;
  logic              in_resp;

  assign any_req = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
  // last_q = port granted most recently; resets to 1 so port 0 wins the first tie.
  logic last_q, last_d;

  assign grant1 = bus.req1 & (~bus.req0 | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && any_req) begin
      last_d = grant1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant1 = bus.req1 & ~bus.req0;
`endif

  assign sel_addr   = grant1 ? bus.addr1 : bus.addr0;
  assign last_cycle = (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          port_d  = grant1;
          we_d    = grant1 ? bus.we1 : bus.we0;
          addr_d  = sel_addr;
          wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
          err_d   = (sel_addr >= AddrLimit);
          wait_d  = 4'd0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (last_cycle) begin
          // Writes and out-of-range accesses return zero data.
          rdata_d = (~we_q & ~err_q) ? bus.mem_rdata : '0;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  // All outputs decode from state so reset forces them low without waiting for a clock.
  assign bus.busy      = (state_q != StIdle);
  assign bus.ack0      = in_resp & ~port_q;
  assign bus.ack1      = in_resp & port_q;
  assign bus.err       = in_resp & err_q;
  assign bus.rdata     = in_resp ? rdata_q : '0;
  assign bus.mem_addr  = in_access ? addr_q : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;
  assign bus.mem_re    = in_access & ~we_q & ~err_q;
  // Single write pulse on the last ACCESS cycle so the memory sees exactly one write edge.
  assign bus.mem_we    = in_access & we_q & ~err_q & last_cycle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter. Two instances: u_dut0 with
// WAIT_CYC=0 and u_dut3 with WAIT_CYC=3, each with its own memory model and reset.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n0;
  logic rst_n3;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (128),
    .WAIT_CYC (0)
  ) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n0),
    .bus     (bus0)
  );

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (128),
    .WAIT_CYC (3)
  ) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n3),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: combinational read, write on rising edge.
  logic [31:0] mem0 [256];
  logic [31:0] mem3 [256];
  assign bus0.mem_rdata = mem0[bus0.mem_addr[7:0]];
  assign bus3.mem_rdata = mem3[bus3.mem_addr[7:0]];

  int we_cnt0 = 0;
  int re_cnt0 = 0;
  int we_cnt3 = 0;
  int re_cnt3 = 0;
  int ack_cnt3 = 0;
  logic [31:0] we_addr0 = '0;
  logic [31:0] we_addr3 = '0;

  always @(posedge clk) begin
    if (bus0.mem_we === 1'b1) begin
      mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      we_cnt0 <= we_cnt0 + 1;
      we_addr0 <= bus0.mem_addr;
    end
    if (bus0.mem_re === 1'b1) re_cnt0 <= re_cnt0 + 1;
    if (bus3.mem_we === 1'b1) begin
      mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
      we_cnt3 <= we_cnt3 + 1;
      we_addr3 <= bus3.mem_addr;
    end
    if (bus3.mem_re === 1'b1) re_cnt3 <= re_cnt3 + 1;
    if ((bus3.ack0 | bus3.ack1) === 1'b1) ack_cnt3 <= ack_cnt3 + 1;
  end

  // Step edges until an ack is seen (bounded); cyc = edges stepped from the grant edge.
  task automatic wait_ack0(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while ((bus0.ack0 | bus0.ack1) !== 1'b1 && cyc < 20);
  endtask

  task automatic wait_ack3(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while ((bus3.ack0 | bus3.ack1) !== 1'b1 && cyc < 20);
  endtask

  task automatic test_reset;
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy0: got %b exp 0", bus0.busy); end
    n_vec++; if ({bus0.ack0, bus0.ack1, bus0.err} !== 3'b000) begin
      n_err++; $display("FAIL rst_ack_err0: got %b exp 000", {bus0.ack0, bus0.ack1, bus0.err}); end
    n_vec++; if ({bus0.mem_we, bus0.mem_re} !== 2'b00) begin
      n_err++; $display("FAIL rst_mem_en0: got %b exp 00", {bus0.mem_we, bus0.mem_re}); end
    n_vec++; if (bus0.mem_addr !== 32'h0 || bus0.rdata !== 32'h0) begin
      n_err++; $display("FAIL rst_addr_rdata0: got %h/%h exp 0/0", bus0.mem_addr, bus0.rdata); end
    n_vec++; if (bus3.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy3: got %b exp 0", bus3.busy); end
    rst_n0 = 1'b1;
    rst_n3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus0.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_no_req: got %b%b exp 00", bus0.busy, bus3.busy); end
  endtask

  task automatic test_write_read;
    int cyc;
    int s_we;
    int s_re;
    s_we = we_cnt0; s_re = re_cnt0;
    bus0.we0 = 1'b1; bus0.addr0 = 32'd5; bus0.wdata0 = 32'hDEADBEEF; bus0.req0 = 1'b1;
    wait_ack0(cyc);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL wr_latency: got %0d exp 2", cyc); end
    n_vec++; if ({bus0.ack0, bus0.ack1, bus0.err} !== 3'b100) begin
      n_err++; $display("FAIL wr_ack: got %b exp 100", {bus0.ack0, bus0.ack1, bus0.err}); end
    n_vec++; if (bus0.rdata !== 32'h0) begin n_err++; $display("FAIL wr_rdata: got %h exp 0", bus0.rdata); end
    bus0.req0 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus0.busy !== 1'b0 || bus0.ack0 !== 1'b0) begin
      n_err++; $display("FAIL wr_idle: got %b%b exp 00", bus0.busy, bus0.ack0); end
    n_vec++; if (we_cnt0 - s_we !== 1 || re_cnt0 - s_re !== 0) begin
      n_err++; $display("FAIL wr_pulses: got we=%0d re=%0d exp 1/0", we_cnt0 - s_we, re_cnt0 - s_re); end
    n_vec++; if (we_addr0 !== 32'd5 || mem0[5] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_mem: got addr=%0d data=%h exp 5/deadbeef", we_addr0, mem0[5]); end

    s_we = we_cnt0; s_re = re_cnt0;
    bus0.we1 = 1'b0; bus0.addr1 = 32'd5; bus0.req1 = 1'b1;
    wait_ack0(cyc);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL rd_latency: got %0d exp 2", cyc); end
    n_vec++; if ({bus0.ack0, bus0.ack1, bus0.err} !== 3'b010) begin
      n_err++; $display("FAIL rd_ack: got %b exp 010", {bus0.ack0, bus0.ack1, bus0.err}); end
    n_vec++; if (bus0.rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_data: got %h exp deadbeef", bus0.rdata); end
    bus0.req1 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (re_cnt0 - s_re !== 1 || we_cnt0 - s_we !== 0) begin
      n_err++; $display("FAIL rd_pulses: got re=%0d we=%0d exp 1/0", re_cnt0 - s_re, we_cnt0 - s_we); end
  endtask

  task automatic test_arbitration;
    int cyc;
    logic [3:0] exp_seq;
`ifdef DMEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    bus0.we0 = 1'b0; bus0.addr0 = 32'd5; bus0.we1 = 1'b0; bus0.addr1 = 32'd5;
    bus0.req0 = 1'b1; bus0.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack0(cyc);
      n_vec++; if (cyc !== ((i == 0) ? 2 : 3)) begin
        n_err++; $display("FAIL arb_spacing[%0d]: got %0d exp %0d", i, cyc, (i == 0) ? 2 : 3); end
      n_vec++; if ({bus0.ack1, bus0.ack0} !== {exp_seq[i], ~exp_seq[i]}) begin
        n_err++; $display("FAIL arb_grant[%0d]: got ack1/ack0=%b%b exp port %0d", i, bus0.ack1,
                          bus0.ack0, exp_seq[i]); end
    end
    bus0.req0 = 1'b0; bus0.req1 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL arb_idle: got %b exp 0", bus0.busy); end
  endtask

  task automatic test_out_of_range;
    int cyc;
    int s_we;
    int s_re;
    s_we = we_cnt3; s_re = re_cnt3;
    bus3.we0 = 1'b0; bus3.addr0 = 32'd200; bus3.req0 = 1'b1;
    wait_ack3(cyc);
    n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL oor_latency: got %0d exp 5", cyc); end
    n_vec++; if ({bus3.ack0, bus3.err} !== 2'b11 || bus3.rdata !== 32'h0) begin
      n_err++; $display("FAIL oor_resp: got ack/err=%b%b rdata=%h exp 11/0", bus3.ack0, bus3.err,
                        bus3.rdata); end
    bus3.req0 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (re_cnt3 - s_re !== 0 || we_cnt3 - s_we !== 0) begin
      n_err++; $display("FAIL oor_mem_en: got re=%0d we=%0d exp 0/0", re_cnt3 - s_re, we_cnt3 - s_we); end
  endtask

  task automatic test_boundary;
    int cyc;
    int s_we;
    int s_re;
    // Last legal word, written across four ACCESS cycles.
    s_we = we_cnt3;
    bus3.we0 = 1'b1; bus3.addr0 = 32'd127; bus3.wdata0 = 32'hA5A50127; bus3.req0 = 1'b1;
    wait_ack3(cyc);
    n_vec++; if (cyc !== 5 || bus3.err !== 1'b0) begin
      n_err++; $display("FAIL wr127_resp: got cyc=%0d err=%b exp 5/0", cyc, bus3.err); end
    bus3.req0 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (we_cnt3 - s_we !== 1 || we_addr3 !== 32'd127) begin
      n_err++; $display("FAIL wr127_pulse: got we=%0d addr=%0d exp 1/127", we_cnt3 - s_we, we_addr3); end
    // First illegal word.
    s_we = we_cnt3;
    bus3.addr0 = 32'd128; bus3.wdata0 = 32'h11111111; bus3.req0 = 1'b1;
    wait_ack3(cyc);
    n_vec++; if (cyc !== 5 || bus3.err !== 1'b1) begin
      n_err++; $display("FAIL wr128_resp: got cyc=%0d err=%b exp 5/1", cyc, bus3.err); end
    bus3.req0 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (we_cnt3 - s_we !== 0) begin
      n_err++; $display("FAIL wr128_pulse: got we=%0d exp 0", we_cnt3 - s_we); end
    // Read back: read enable held for every ACCESS cycle.
    s_re = re_cnt3;
    bus3.we0 = 1'b0; bus3.addr0 = 32'd127; bus3.req0 = 1'b1;
    wait_ack3(cyc);
    n_vec++; if (cyc !== 5 || bus3.rdata !== 32'hA5A50127 || bus3.err !== 1'b0) begin
      n_err++; $display("FAIL rd127: got cyc=%0d rdata=%h err=%b exp 5/a5a50127/0", cyc, bus3.rdata,
                        bus3.err); end
    bus3.req0 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (re_cnt3 - s_re !== 4) begin
      n_err++; $display("FAIL rd127_re_cycles: got %0d exp 4", re_cnt3 - s_re); end
  endtask

  task automatic test_back_to_back;
    int c1;
    int c2;
    int s_re;
    s_re = re_cnt3;
    bus3.we1 = 1'b0; bus3.addr1 = 32'd127; bus3.req1 = 1'b1;
    wait_ack3(c1);
    n_vec++; if (c1 !== 5 || bus3.ack1 !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: got cyc=%0d ack1=%b exp 5/1", c1, bus3.ack1); end
    wait_ack3(c2);
    n_vec++; if (c2 !== 6 || bus3.ack1 !== 1'b1 || bus3.rdata !== 32'hA5A50127) begin
      n_err++; $display("FAIL b2b_second: got cyc=%0d ack1=%b rdata=%h exp 6/1/a5a50127", c2,
                        bus3.ack1, bus3.rdata); end
    bus3.req1 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (re_cnt3 - s_re !== 8 || bus3.busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got re=%0d busy=%b exp 8/0", re_cnt3 - s_re, bus3.busy); end
  endtask

  task automatic test_reset_abort;
    int s_we;
    int s_ack;
    s_we = we_cnt3; s_ack = ack_cnt3;
    bus3.we0 = 1'b1; bus3.addr0 = 32'd7; bus3.wdata0 = 32'h12345678; bus3.req0 = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus3.busy !== 1'b1 || bus3.mem_addr !== 32'd7 || bus3.mem_we !== 1'b0) begin
      n_err++; $display("FAIL abort_access1: got busy=%b addr=%0d we=%b exp 1/7/0", bus3.busy,
                        bus3.mem_addr, bus3.mem_we); end
    @(posedge clk); #1;
    rst_n3 = 1'b0;
    #1;
    n_vec++; if (bus3.busy !== 1'b0 || bus3.mem_addr !== 32'h0 || bus3.mem_wdata !== 32'h0 ||
                 bus3.mem_we !== 1'b0 || bus3.ack0 !== 1'b0) begin
      n_err++; $display("FAIL abort_immediate: got busy=%b addr=%h wdata=%h we=%b ack0=%b exp all 0",
                        bus3.busy, bus3.mem_addr, bus3.mem_wdata, bus3.mem_we, bus3.ack0); end
    bus3.req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n3 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (we_cnt3 - s_we !== 0 || ack_cnt3 - s_ack !== 0 || bus3.busy !== 1'b0) begin
      n_err++; $display("FAIL abort_after: got we=%0d ack=%0d busy=%b exp 0/0/0", we_cnt3 - s_we,
                        ack_cnt3 - s_ack, bus3.busy); end
  endtask

  initial begin
    rst_n0 = 1'b0;
    rst_n3 = 1'b0;
    bus0.req0 = 1'b0; bus0.req1 = 1'b0; bus0.we0 = 1'b0; bus0.we1 = 1'b0;
    bus0.addr0 = '0; bus0.addr1 = '0; bus0.wdata0 = '0; bus0.wdata1 = '0;
    bus3.req0 = 1'b0; bus3.req1 = 1'b0; bus3.we0 = 1'b0; bus3.we1 = 1'b0;
    bus3.addr0 = '0; bus3.addr1 = '0; bus3.wdata0 = '0; bus3.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_arbitration();
    test_out_of_range();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
